// File: rtl/bridge_arbiter_pkg.sv
// Shared constants, state encoding and request record for the peripheral
// bridge arbiter.
package bridge_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int EXC_W  = 5;

    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;

    localparam logic [1:0] DM_WORD = 2'd0;
    localparam logic [1:0] DM_HALF = 2'd1;
    localparam logic [1:0] DM_BYTE = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
        logic              we;
        logic [1:0]        op;
        logic              load;
        logic              store;
    } req_t;

    // Out-of-range accesses are typed by direction.
    function automatic logic [EXC_W-1:0] oor_type(input logic store);
        return store ? EXC_ADES : EXC_ADEL;
    endfunction

endpackage

// File: rtl/bridge_arbiter_if.sv
// Bus bundle for the two requesting ports and the bridge side.
interface bridge_arbiter_if;
    import bridge_arbiter_pkg::*;

    logic              req0, req1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wd0, wd1;
    logic              we0, we1;
    logic [1:0]        op0, op1;
    logic              load0, load1, store0, store1;
    logic              gnt0, gnt1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              exc;
    logic [EXC_W-1:0]  exc_type;
    logic [ADDR_W-1:0] br_addr;
    logic [DATA_W-1:0] br_wd;
    logic              br_we;
    logic [1:0]        br_op;
    logic              br_load, br_store;
    logic [DATA_W-1:0] br_rd;
    logic              br_exception;
    logic [EXC_W-1:0]  br_exception_type;
    logic              br_oor;

    modport slave (
        input  req0, req1, addr0, addr1, wd0, wd1, we0, we1, op0, op1,
               load0, load1, store0, store1,
               br_rd, br_exception, br_exception_type, br_oor,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, exc, exc_type,
               br_addr, br_wd, br_we, br_op, br_load, br_store
    );

    modport master (
        output req0, req1, addr0, addr1, wd0, wd1, we0, we1, op0, op1,
               load0, load1, store0, store1,
               br_rd, br_exception, br_exception_type, br_oor,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, exc, exc_type,
               br_addr, br_wd, br_we, br_op, br_load, br_store
    );

endinterface

// File: rtl/bridge_arbiter_rr_pick2.sv
// Two-input round-robin picker: on a tie the port not served last wins.
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);
    assign o_gnt[0] = i_req[0] & (~i_req[1] |  i_last);
    assign o_gnt[1] = i_req[1] & (~i_req[0] | ~i_last);
endmodule

// File: rtl/bridge_arbiter.sv
// Shares the peripheral bridge between two masters: round-robin grant,
// one-cycle registered bridge access, registered response with exception merge.
module bridge_arbiter
    import bridge_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    bridge_arbiter_if.slave  bus
);

    arb_state_e        r_state, w_next;
    req_t              r_req;
    logic              r_owner;
    logic              r_last;
    logic [DATA_W-1:0] r_rdata;
    logic              r_exc;
    logic [EXC_W-1:0]  r_exc_type;

    logic [1:0]        w_req, w_pick;
    logic              w_arb, w_issue, w_take;
    req_t              w_in;
    logic              w_exc;
    logic [EXC_W-1:0]  w_type;

    assign w_req   = {bus.req1, bus.req0};
    assign w_arb   = (r_state == ARB_IDLE) || (r_state == ARB_RESP);
    assign w_issue = (r_state == ARB_ISSUE);
    assign w_take  = w_arb && (w_req != 2'b00);

    rr_pick2 u_pick (
        .i_req  (w_req),
        .i_last (r_last),
        .o_gnt  (w_pick)
    );

    assign w_in = w_pick[1]
        ? '{addr: bus.addr1, wd: bus.wd1, we: bus.we1, op: bus.op1, load: bus.load1, store: bus.store1}
        : '{addr: bus.addr0, wd: bus.wd0, we: bus.we0, op: bus.op0, load: bus.load0, store: bus.store0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ARB_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_IDLE:  if (w_take) w_next = ARB_ISSUE;
            ARB_ISSUE: w_next = ARB_RESP;
            ARB_RESP:  w_next = w_take ? ARB_ISSUE : ARB_IDLE;
            default:   w_next = ARB_IDLE;
        endcase
    end

    // Bridge exception has priority; out-of-range is typed by access kind.
    always_comb begin
        w_exc  = 1'b0;
        w_type = '0;
        if (bus.br_exception) begin
            w_exc  = 1'b1;
            w_type = bus.br_exception_type;
        end else if (bus.br_oor) begin
            w_exc  = 1'b1;
            w_type = oor_type(r_req.store);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req      <= '0;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_rdata    <= '0;
            r_exc      <= 1'b0;
            r_exc_type <= '0;
        end else begin
            if (w_take) begin
                r_req   <= w_in;
                r_owner <= w_pick[1];
                r_last  <= w_pick[1];
            end
            if (w_issue) begin
                r_rdata    <= w_exc ? '0 : bus.br_rd;
                r_exc      <= w_exc;
                r_exc_type <= w_type;
            end
        end
    end

    assign bus.gnt0     = w_arb & w_pick[0];
    assign bus.gnt1     = w_arb & w_pick[1];
    assign bus.rvalid0  = (r_state == ARB_RESP) & ~r_owner;
    assign bus.rvalid1  = (r_state == ARB_RESP) &  r_owner;
    assign bus.rdata    = r_rdata;
    assign bus.exc      = r_exc;
    assign bus.exc_type = r_exc_type;

    // Outside ISSUE the bridge sees address 0 and no access at all.
    assign bus.br_addr  = w_issue ? r_req.addr  : '0;
    assign bus.br_wd    = w_issue ? r_req.wd    : '0;
    assign bus.br_op    = w_issue ? r_req.op    : '0;
    assign bus.br_load  = w_issue & r_req.load;
    assign bus.br_store = w_issue & r_req.store;
    assign bus.br_we    = w_issue & r_req.we & ~bus.br_exception & ~bus.br_oor;

endmodule

// File: tb/tb_bridge_arbiter.sv
// Self-checking bench: directed scenarios plus randomized two-master traffic
// against a cycle-level transaction model and a behavioural bridge.
module tb_bridge_arbiter;
    import bridge_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bridge_arbiter_if bif ();
    bridge_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bif));

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // master-side drive
    logic treq [2];
    req_t tf   [2];
    assign bif.req0 = treq[0];  assign bif.req1 = treq[1];
    assign bif.addr0 = tf[0].addr;  assign bif.addr1 = tf[1].addr;
    assign bif.wd0 = tf[0].wd;      assign bif.wd1 = tf[1].wd;
    assign bif.we0 = tf[0].we;      assign bif.we1 = tf[1].we;
    assign bif.op0 = tf[0].op;      assign bif.op1 = tf[1].op;
    assign bif.load0 = tf[0].load;  assign bif.load1 = tf[1].load;
    assign bif.store0 = tf[0].store; assign bif.store1 = tf[1].store;

    // behavioural bridge, with a directed override
    typedef struct packed {
        logic             exc;
        logic [EXC_W-1:0] typ;
        logic             oor;
        logic [31:0]      rd;
    } brsp_t;

    logic             ovr_en = 1'b0;
    logic [31:0]      ovr_rd = '0;
    logic             ovr_exc = 1'b0;
    logic [EXC_W-1:0] ovr_type = '0;
    logic             ovr_oor = 1'b0;

    function automatic brsp_t bridge_fn(input logic [31:0] a, input logic [1:0] op, input logic st);
        brsp_t r;
        r.oor = (a < 32'h7F00) || (a > 32'h7F23);
        r.exc = !r.oor && ((op == DM_WORD && a[1:0] != 2'b00) || (op == DM_HALF && a[0]));
        r.typ = r.exc ? (st ? EXC_ADES : EXC_ADEL) : 5'd0;
        r.rd  = {a[15:0], ~a[15:0]};
        return r;
    endfunction

    brsp_t w_br;
    always_comb begin
        w_br = ovr_en ? {ovr_exc, ovr_type, ovr_oor, ovr_rd}
                      : bridge_fn(bif.br_addr, bif.br_op, bif.br_store);
        bif.br_rd             = w_br.rd;
        bif.br_exception      = w_br.exc;
        bif.br_exception_type = w_br.typ;
        bif.br_oor            = w_br.oor;
    end

    // transaction model: grant at N, bridge access at N+1, response at N+2
    logic             m_busy = 0, m_due = 0, m_last = 1, m_own = 0, n_own = 0;
    req_t             m_f = '0;
    logic [31:0]      m_rdata = '0, n_rdata = '0;
    logic             m_exc = 0, n_exc = 0;
    logic [EXC_W-1:0] m_type = '0, n_type = '0;

    always @(negedge clk) begin
        logic [1:0] eg;
        brsp_t b;
        if (!rst_n) begin
            m_busy = 0; m_due = 0; m_last = 1;
            m_rdata = '0; m_exc = 0; m_type = '0;
            chk("rst_ctl", {bif.gnt0, bif.gnt1, bif.rvalid0, bif.rvalid1, bif.br_we,
                            bif.br_load, bif.br_store, bif.br_op, bif.exc, bif.exc_type}, 0);
            chk("rst_rdata", bif.rdata, 0);
            chk("rst_braddr", {bif.br_addr, bif.br_wd}, 0);
        end else begin
            eg = 2'b00;
            if (!m_busy) begin
                if (treq[0] && treq[1]) eg = m_last ? 2'b01 : 2'b10;
                else                    eg = {treq[1], treq[0]};
            end
            chk("gnt", {bif.gnt1, bif.gnt0}, eg);

            if (m_busy) begin
                b = ovr_en ? {ovr_exc, ovr_type, ovr_oor, ovr_rd}
                           : bridge_fn(m_f.addr, m_f.op, m_f.store);
                chk("br_addr", bif.br_addr, m_f.addr);
                chk("br_wd", bif.br_wd, m_f.wd);
                chk("br_kind", {bif.br_op, bif.br_load, bif.br_store}, {m_f.op, m_f.load, m_f.store});
                chk("br_we", bif.br_we, m_f.we && !b.exc && !b.oor);
                n_exc   = b.exc || b.oor;
                n_type  = b.exc ? b.typ : (b.oor ? (m_f.store ? EXC_ADES : EXC_ADEL) : 5'd0);
                n_rdata = n_exc ? 32'd0 : b.rd;
                n_own   = m_own;
            end else begin
                chk("br_idle", {bif.br_addr, bif.br_wd, bif.br_op, bif.br_we, bif.br_load, bif.br_store}, 0);
            end

            if (m_due) begin
                m_rdata = n_rdata; m_exc = n_exc; m_type = n_type;
                chk("rvalid", {bif.rvalid1, bif.rvalid0}, n_own ? 2'b10 : 2'b01);
            end else begin
                chk("rvalid_idle", {bif.rvalid1, bif.rvalid0}, 0);
            end
            chk("rdata", bif.rdata, m_rdata);
            chk("exc", {bif.exc, bif.exc_type}, {m_exc, m_type});

            m_due  = m_busy;
            m_busy = (eg != 2'b00);
            if (eg != 2'b00) begin
                m_f    = eg[1] ? tf[1] : tf[0];
                m_own  = eg[1];
                m_last = eg[1];
            end
        end
    end

    task automatic xact(input int p, input logic [31:0] a, input logic [31:0] wd, input logic we,
                        input logic [1:0] op, input logic [31:0] exp_rd, input logic exp_exc,
                        input logic [4:0] exp_t, input logic exp_brwe, input string tag);
        logic got;
        @(posedge clk); #1;
        tf[p] = '{addr: a, wd: wd, we: we, op: op, load: !we, store: we};
        treq[p] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((p == 0) ? bif.gnt0 : bif.gnt1) begin got = 1'b1; break; end
        end
        chk({tag, "_gnt"}, got, 1);
        @(posedge clk); #1;
        treq[p] = 1'b0;
        @(negedge clk);
        chk({tag, "_braddr"}, bif.br_addr, a);
        chk({tag, "_brwe"}, bif.br_we, exp_brwe);
        chk({tag, "_brwd"}, bif.br_wd, wd);
        @(negedge clk);
        chk({tag, "_rvalid"}, (p == 0) ? bif.rvalid0 : bif.rvalid1, 1);
        chk({tag, "_rdata"}, bif.rdata, exp_rd);
        chk({tag, "_exc"}, {bif.exc, bif.exc_type}, {exp_exc, exp_t});
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.addr  = ($urandom_range(3) == 0) ? $urandom : 32'h7F00 + 32'($urandom_range(39));
        r.wd    = $urandom;
        r.we    = 1'($urandom_range(1));
        r.op    = 2'($urandom_range(2));
        r.load  = !r.we;
        r.store = r.we;
        return r;
    endfunction

    initial begin
        int order [4];
        int n;
        logic g [2];
        treq[0] = 0; treq[1] = 0; tf[0] = '0; tf[1] = '0;
        repeat (2) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;

        // tie: both held for four grants
        @(posedge clk); #1;
        tf[0] = '{addr: 32'h7F10, wd: 0, we: 0, op: DM_WORD, load: 1, store: 0};
        tf[1] = '{addr: 32'h7F14, wd: 0, we: 0, op: DM_WORD, load: 1, store: 0};
        treq[0] = 1; treq[1] = 1;
        n = 0;
        for (int i = 0; i < 20 && n < 4; i++) begin
            @(negedge clk);
            if (bif.gnt0) begin order[n] = 0; n++; end
            else if (bif.gnt1) begin order[n] = 1; n++; end
        end
        @(posedge clk); #1; treq[0] = 0; treq[1] = 0;
        chk("tie_count", n, 4);
        for (int i = 0; i < 4; i++) chk("tie_order", order[i], i % 2);
        repeat (3) @(negedge clk);

        ovr_en = 1; ovr_rd = 32'h0000_1234; ovr_exc = 0; ovr_type = 0; ovr_oor = 0;
        xact(0, 32'h7F04, 32'h0, 0, DM_WORD, 32'h1234, 0, 5'd0, 0, "single_rd");
        ovr_rd = 32'hDEAD_BEEF; ovr_exc = 1; ovr_type = EXC_ADES;
        xact(1, 32'h7F08, 32'hAA, 1, DM_WORD, 32'h0, 1, EXC_ADES, 0, "fault_st");
        ovr_en = 0;
        xact(0, 32'h0000_8000, 32'h0, 0, DM_WORD, 32'h0, 1, EXC_ADEL, 0, "oor_ld");
        xact(1, 32'h7F00, 32'h5, 1, DM_WORD, 32'h7F00_80FF, 0, 5'd0, 1, "timer_wr");
        @(negedge clk);
        chk("timer_wr_we_off", bif.br_we, 0);

        // reset during ISSUE
        @(posedge clk); #1;
        tf[0] = '{addr: 32'h7F00, wd: 9, we: 1, op: DM_WORD, load: 0, store: 1};
        treq[0] = 1;
        @(negedge clk);
        chk("rstmid_gnt", bif.gnt0, 1);
        @(posedge clk); #1; treq[0] = 0;
        #1 chk("rstmid_we_pre", bif.br_we, 1);
        rst_n = 1'b0;
        #1 chk("rstmid_we_drop", bif.br_we, 0);
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_no_rvalid", {bif.rvalid0, bif.rvalid1}, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        xact(0, 32'h7F04, 32'h0, 0, DM_WORD, 32'h7F04_80FB, 0, 5'd0, 0, "post_rst");

        // randomized traffic, model checks every cycle
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            g[0] = bif.gnt0; g[1] = bif.gnt1;
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (g[p]) treq[p] = 0;
                else if (treq[p] && $urandom_range(15) == 0) treq[p] = 0;
                if (!treq[p] && $urandom_range(1) == 1) begin
                    tf[p] = rand_req();
                    treq[p] = 1;
                end
            end
        end
        @(negedge clk);
        g[0] = bif.gnt0; g[1] = bif.gnt1;
        @(posedge clk); #1; treq[0] = 0; treq[1] = 0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
